fft_frame_loader: RTL and testbench

Producer-side front end for the 16-point radix-4 FFT core. Collects a stream of ADC samples into N-sample frames using two register banks (ping-pong). Presents each completed frame on a parallel bus held stable for the whole transform, issues a one-cycle start pulse, and waits for the core's done pulse. Sits between the audio sample source and the FFT in the visualizer datapath.

---
 rtl/fft_pkg.sv | 19 +
 rtl/fft_sample_bank.sv | 35 +++
 rtl/fft_frame_loader.sv | 153 +++++++++++++++
 tb/tb_fft_frame_loader.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared types and constants for the FFT front end.
//   loader_state_t : frame loader FSM states
//   FFT_WIDTH      : default sample width
//   FFT_N          : default samples per frame
//   DROP_SAT       : value at which drop_count stops counting
package fft_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2
  } loader_state_t;

  localparam int unsigned FFT_WIDTH = 12;
  localparam int unsigned FFT_N     = 16;

  localparam logic [7:0] DROP_SAT = 8'd255;

endpackage

// File: rtl/fft_sample_bank.sv
// One frame buffer: N x WIDTH registers, cleared by reset, written one
// sample per cycle, read out in parallel.
// Ports:
//   clk, rst : clock, synchronous active-high reset (clears all entries)
//   we       : write enable
//   waddr    : entry written when we is high
//   wdata    : sample to store
//   rdata    : all N entries, index 0 first
module fft_sample_bank #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned N     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [$clog2(N)-1:0] waddr,
  input  logic [WIDTH-1:0]     wdata,
  output logic [WIDTH-1:0]     rdata [0:N-1]
);

  logic [WIDTH-1:0] mem [0:N-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(N); i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem;

endmodule

// File: rtl/fft_frame_loader.sv
// Ping-pong frame loader in front of the radix-4 FFT core. Samples fill one
// bank while the other bank is presented to the FFT; a completed frame is
// swapped in, a one-cycle start pulse is issued, and the loader waits for
// fft_done (or gives up after TIMEOUT cycles).
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   sample_valid  : sample_data valid this cycle
//   sample_data   : incoming sample
//   fft_start     : one-cycle start pulse to the FFT
//   fft_done      : one-cycle done pulse from the FFT (ignored outside BUSY)
//   time_samples  : present-bank frame, index 0 oldest
//   busy          : high in START or BUSY
//   frame_count   : frames acknowledged by fft_done, wraps
//   drop_count    : samples discarded while a frame waits, saturates
//   timeout_err   : sticky, set when BUSY times out
// Build option: define FFT_LOADER_OFFSET_BINARY_EN to accept offset-binary
// ADC codes (MSB inverted before storage).
module fft_frame_loader
  import fft_pkg::*;
#(
  parameter int unsigned WIDTH   = FFT_WIDTH,
  parameter int unsigned N       = FFT_N,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_valid,
  input  logic [WIDTH-1:0] sample_data,
  output logic             fft_start,
  input  logic             fft_done,
  output logic [WIDTH-1:0] time_samples [0:N-1],
  output logic             busy,
  output logic [15:0]      frame_count,
  output logic [7:0]       drop_count,
  output logic             timeout_err
);

  localparam int unsigned IdxW  = $clog2(N);
  localparam int unsigned TcntW = $clog2(TIMEOUT + 1);

  loader_state_t    state;
  logic             bank_sel;
  logic             pending;
  logic [IdxW-1:0]  wr_idx;
  logic [TcntW-1:0] tcnt;

  logic             wr_en;
  logic             frame_done;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] rd0 [0:N-1];
  logic [WIDTH-1:0] rd1 [0:N-1];

  // A waiting frame blocks all writes so the fill bank is not overwritten.
  assign wr_en      = sample_valid && !pending;
  assign frame_done = wr_en && (wr_idx == IdxW'(N - 1));

`ifdef FFT_LOADER_OFFSET_BINARY_EN
  assign wdata = {~sample_data[WIDTH-1], sample_data[WIDTH-2:0]};
`else
  assign wdata = sample_data;
`endif

  // bank_sel=0 presents bank 0 and fills bank 1, and vice versa.
  fft_sample_bank #(
    .WIDTH (WIDTH),
    .N     (N)
  ) u_bank0 (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_en && bank_sel),
    .waddr (wr_idx),
    .wdata (wdata),
    .rdata (rd0)
  );

  fft_sample_bank #(
    .WIDTH (WIDTH),
    .N     (N)
  ) u_bank1 (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_en && !bank_sel),
    .waddr (wr_idx),
    .wdata (wdata),
    .rdata (rd1)
  );

  always_comb begin
    for (int i = 0; i < int'(N); i++) begin
      time_samples[i] = bank_sel ? rd1[i] : rd0[i];
    end
  end

  assign fft_start = (state == START);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      bank_sel    <= 1'b0;
      pending     <= 1'b0;
      wr_idx      <= '0;
      tcnt        <= '0;
      frame_count <= '0;
      drop_count  <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_idx <= wr_idx + 1'b1;
      end

      if (sample_valid && pending && (drop_count != DROP_SAT)) begin
        drop_count <= drop_count + 1'b1;
      end

      unique case (state)
        IDLE: begin
          if (pending) begin
            bank_sel <= ~bank_sel;
            pending  <= 1'b0;
            state    <= START;
          end else if (frame_done) begin
            bank_sel <= ~bank_sel;
            state    <= START;
          end
        end
        START: begin
          if (frame_done) begin
            pending <= 1'b1;
          end
          tcnt  <= '0;
          state <= BUSY;
        end
        BUSY: begin
          if (frame_done) begin
            pending <= 1'b1;
          end
          if (fft_done) begin
            frame_count <= frame_count + 1'b1;
            state       <= IDLE;
          end else if (tcnt == TcntW'(TIMEOUT - 1)) begin
            timeout_err <= 1'b1;
            state       <= IDLE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_frame_loader.sv
// Scoreboard bench for fft_frame_loader: the driver feeds samples and keeps a
// frame-level reference model; expected frames and per-cycle status are
// queued/snapshotted and checked by an independent monitor on the falling edge.
module tb_fft_frame_loader;

  localparam int W  = 12;
  localparam int N  = 16;
  localparam int TO = 15;

  typedef logic [W-1:0]   samp_t;
  typedef logic [N*W-1:0] frame_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sample_valid = 1'b0;
  samp_t       sample_data = '0;
  logic        fft_done = 1'b0;
  logic        fft_start;
  samp_t       time_samples [0:N-1];
  logic        busy;
  logic [15:0] frame_count;
  logic [7:0]  drop_count;
  logic        timeout_err;

  fft_frame_loader #(
    .WIDTH   (W),
    .N       (N),
    .TIMEOUT (TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .fft_start    (fft_start),
    .fft_done     (fft_done),
    .time_samples (time_samples),
    .busy         (busy),
    .frame_count  (frame_count),
    .drop_count   (drop_count),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  // ---------------- reference model ----------------
  int          m_phase;     // 0 idle, 1 start pulse, 2 waiting for done
  int          m_wait;
  bit          m_full_v;    // a completed frame is waiting for the FFT
  frame_t      m_full;
  frame_t      m_present;
  samp_t       m_cur[$];
  logic [15:0] m_frames;
  int          m_drops;
  bit          m_err;

  // Expected start pulses: cycle and frame contents.
  int     exp_cyc[$];
  frame_t exp_frm[$];

  // Status the DUT must show during cycle s_cyc.
  int          s_cyc = -1;
  bit          s_busy, s_start, s_err;
  logic [15:0] s_frames;
  int          s_drops;
  frame_t      s_present;

  bit chk_en   = 1'b0;
  int done_at  = -1;
  int cur_delay = 4;    // cycles from start to done; -1 never; -2 random
  bit spur_en  = 1'b0;

  function automatic samp_t store(samp_t d);
`ifdef FFT_LOADER_OFFSET_BINARY_EN
    return d ^ samp_t'(1 << (W - 1));
`else
    return d;
`endif
  endfunction

  task automatic model_reset();
    m_phase   = 0;
    m_wait    = 0;
    m_full_v  = 0;
    m_full    = '0;
    m_present = '0;
    m_cur.delete();
    m_frames  = '0;
    m_drops   = 0;
    m_err     = 0;
    done_at   = -1;
  endtask

  task automatic step(input bit r, input bit v, input samp_t d, input bit dn);
    bit     launch;
    bit     accept;
    frame_t lf;
    frame_t tmp;
    int     next;
    s_cyc     = cyc;
    s_busy    = (m_phase != 0);
    s_start   = (m_phase == 1);
    s_frames  = m_frames;
    s_drops   = m_drops;
    s_err     = m_err;
    s_present = m_present;
    if (r) begin
      model_reset();
      return;
    end
    launch = 0;
    lf     = '0;
    next   = m_phase;
    accept = v && !m_full_v;
    if (v && m_full_v && m_drops < 255) m_drops++;
    case (m_phase)
      0: if (m_full_v) begin
        launch   = 1;
        lf       = m_full;
        m_full_v = 0;
      end
      1: begin
        next   = 2;
        m_wait = 0;
      end
      default: begin
        if (dn) begin
          m_frames = m_frames + 16'd1;
          next     = 0;
        end else if (m_wait == TO - 1) begin
          m_err = 1;
          next  = 0;
        end else begin
          m_wait++;
        end
      end
    endcase
    if (accept) begin
      m_cur.push_back(store(d));
      if (m_cur.size() == N) begin
        for (int i = 0; i < N; i++) tmp[i*W +: W] = m_cur[i];
        m_cur.delete();
        if (m_phase == 0) begin
          launch = 1;
          lf     = tmp;
        end else begin
          m_full_v = 1;
          m_full   = tmp;
        end
      end
    end
    if (launch) begin
      int dly;
      next      = 1;
      m_present = lf;
      exp_cyc.push_back(cyc + 1);
      exp_frm.push_back(lf);
      dly = (cur_delay == -2) ? int'($urandom_range(1, TO + 2)) : cur_delay;
      done_at = (dly < 0) ? -1 : cyc + 1 + dly;
    end
    m_phase = next;
  endtask

  // One clock cycle of stimulus; inputs change 1 time unit after the edge.
  task automatic drive(input bit r, input bit v, input samp_t d);
    bit dn;
    @(posedge clk);
    #1;
    dn = (cyc == done_at) || (spur_en && ($urandom_range(0, 19) == 0));
    rst          = r;
    sample_valid = v;
    sample_data  = d;
    fft_done     = dn;
    step(r, v, d, dn);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0);
  endtask

  // ---------------- monitor ----------------
  task automatic check(input string name, input logic [N*W-1:0] got,
                       input logic [N*W-1:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, got, want);
    end
  endtask

  frame_t got_frame;

  always @(negedge clk) begin
    if (chk_en && s_cyc == cyc) begin
      for (int i = 0; i < N; i++) got_frame[i*W +: W] = time_samples[i];
      check("busy", busy, s_busy);
      check("fft_start", fft_start, s_start);
      check("frame_count", frame_count, s_frames);
      check("drop_count", drop_count, s_drops);
      check("timeout_err", timeout_err, s_err);
      check("time_samples", got_frame, s_present);
      while (exp_cyc.size() > 0 && exp_cyc[0] < cyc) begin
        tests++;
        fails++;
        $display("FAIL start_missing: no pulse, expected at cycle %0d", exp_cyc[0]);
        void'(exp_cyc.pop_front());
        void'(exp_frm.pop_front());
      end
      if (fft_start === 1'b1) begin
        if (exp_cyc.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL start_spurious: pulse at cycle %0d, expected none", cyc);
        end else begin
          check("start_cycle", cyc, exp_cyc.pop_front());
          check("start_frame", got_frame, exp_frm.pop_front());
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    drive(1'b1, 1'b0, '0);
    chk_en = 1'b1;
    drive(1'b1, 1'b0, '0);
    idle(3);

    // Frame 1..16, done 4 cycles after start.
    cur_delay = 4;
    for (int i = 1; i <= 16; i++) drive(1'b0, 1'b1, samp_t'(i));
    idle(12);

    // 32 back-to-back samples, short and long FFT latency.
    for (int i = 17; i <= 48; i++) drive(1'b0, 1'b1, samp_t'(i));
    idle(12);
    cur_delay = 12;
    for (int i = 49; i <= 90; i++) drive(1'b0, 1'b1, samp_t'(i));
    idle(30);

    // Timeout: done never arrives; then done exactly on the last BUSY cycle.
    cur_delay = -1;
    for (int i = 0; i < 16; i++) drive(1'b0, 1'b1, samp_t'(100 + i));
    idle(25);
    cur_delay = TO;
    for (int i = 0; i < 16; i++) drive(1'b0, 1'b1, samp_t'(200 + i));
    idle(25);

    // Reset mid-frame, then a constant frame.
    cur_delay = 4;
    for (int i = 0; i < 9; i++) drive(1'b0, 1'b1, samp_t'(300 + i));
    drive(1'b1, 1'b0, '0);
    for (int i = 0; i < 16; i++) drive(1'b0, 1'b1, samp_t'('h0A5));
    idle(12);

    // Offset-binary boundary codes.
    for (int i = 0; i < 16; i++) drive(1'b0, 1'b1, samp_t'('h800));
    idle(12);
    for (int i = 0; i < 16; i++) drive(1'b0, 1'b1, samp_t'(i[0] ? 'h000 : 'hFFF));
    idle(12);

    // Randomized traffic.
    cur_delay = -2;
    spur_en   = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      drive(($urandom_range(0, 499) == 0), ($urandom_range(0, 9) < 7),
            samp_t'($urandom));
    end
    spur_en = 1'b0;
    idle(40);

    check("queue_drained", exp_cyc.size(), 0);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
